prga: RTL and testbench

Pseudo-random generation stage of the ARC4 decryption unit: the consumer of the S-box that key scheduling leaves in the shared S memory. It reads a length-prefixed ciphertext from CT memory and evolves S on the fly. It writes the length-prefixed plaintext (keystream XOR ciphertext) to PT memory. The top-level controller starts it with the en/rdy handshake once key scheduling reports ready.

---
 rtl/arc4_pkg.sv | 35 +++
 rtl/prga.sv | 157 +++++++++++++++
 tb/tb_prga.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 decryption-unit definitions: FSM state types for the key
// scheduling and pseudo-random generation stages, fixed addresses and the printable range.
package arc4_pkg;

  // Key scheduling stage states. They live here so both stages share one package.
  typedef enum logic [2:0] {
    KSA_IDLE,
    KSA_INIT,
    KSA_RD_I,
    KSA_RD_J,
    KSA_WR_I,
    KSA_WR_J
  } ksa_state_t;

  typedef enum logic [3:0] {
    PRGA_IDLE,
    PRGA_LEN_RD,
    PRGA_LEN_WR,
    PRGA_RD_I,
    PRGA_RD_J,
    PRGA_WR_I,
    PRGA_WR_J,
    PRGA_RD_PAD,
    PRGA_WR_PT
  } prga_state_t;

  localparam logic [7:0] LEN_ADDR = 8'd0;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/prga.sv
// ARC4 pseudo-random generation stage: evolves the S-box and writes the
// length-prefixed plaintext. Optional printable check: PRGA_PRINTABLE_CHECK_EN.
module prga
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren,
  output logic       pt_ok
);

  prga_state_t state, state_nxt;

  logic [7:0] i, j, k, len;
  logic [7:0] si, sj, ctb;
  logic [7:0] j_sum;
  logic [7:0] pad_addr;

  // S[i] arrives in RD_J while j still holds its old value, so the new j
  // is formed combinationally to address S[j] in the same cycle.
  assign j_sum    = j + s_rddata;
  assign pad_addr = si + sj;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= PRGA_IDLE;
      i     <= 8'd0;
      j     <= 8'd0;
      k     <= 8'd0;
      len   <= 8'd0;
      si    <= 8'd0;
      sj    <= 8'd0;
      ctb   <= 8'd0;
    end else begin
      state <= state_nxt;
      unique case (state)
        PRGA_IDLE: begin
          if (en) begin
            i <= 8'd0;
            j <= 8'd0;
            k <= 8'd0;
          end
        end
        PRGA_LEN_WR: begin
          len <= ct_rddata;
          k   <= 8'd1;
        end
        PRGA_RD_I: i <= i + 8'd1;
        PRGA_RD_J: begin
          si <= s_rddata;
          j  <= j_sum;
        end
        PRGA_WR_I: begin
          sj  <= s_rddata;
          ctb <= ct_rddata;
        end
        PRGA_WR_PT: k <= k + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_nxt = state;
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    unique case (state)
      PRGA_IDLE: begin
        rdy = 1'b1;
        if (en) state_nxt = PRGA_LEN_RD;
      end
      PRGA_LEN_RD: begin
        ct_addr   = LEN_ADDR;
        state_nxt = PRGA_LEN_WR;
      end
      PRGA_LEN_WR: begin
        pt_addr   = LEN_ADDR;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        state_nxt = (ct_rddata == 8'd0) ? PRGA_IDLE : PRGA_RD_I;
      end
      PRGA_RD_I: begin
        s_addr    = i + 8'd1;
        state_nxt = PRGA_RD_J;
      end
      PRGA_RD_J: begin
        s_addr    = j_sum;
        ct_addr   = k;
        state_nxt = PRGA_WR_I;
      end
      PRGA_WR_I: begin
        // When i == j both swap writes carry the same value, which is harmless.
        s_addr    = i;
        s_wrdata  = s_rddata;
        s_wren    = 1'b1;
        state_nxt = PRGA_WR_J;
      end
      PRGA_WR_J: begin
        s_addr    = j;
        s_wrdata  = si;
        s_wren    = 1'b1;
        state_nxt = PRGA_RD_PAD;
      end
      PRGA_RD_PAD: begin
        s_addr    = pad_addr;
        state_nxt = PRGA_WR_PT;
      end
      PRGA_WR_PT: begin
        pt_addr   = k;
        pt_wrdata = s_rddata ^ ctb;
        pt_wren   = 1'b1;
        state_nxt = (k == len) ? PRGA_IDLE : PRGA_RD_I;
      end
      default: state_nxt = PRGA_IDLE;
    endcase
  end

`ifdef PRGA_PRINTABLE_CHECK_EN
  logic ok;

  // Sticky: once a non-printable byte is written, stays low until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      ok <= 1'b1;
    end else if (state == PRGA_IDLE && en) begin
      ok <= 1'b1;
    end else if (pt_wren && state == PRGA_WR_PT && !is_printable(pt_wrdata)) begin
      ok <= 1'b0;
    end
  end

  assign pt_ok = ok;
`else
  assign pt_ok = 1'b1;
`endif

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: behavioural S/CT/PT memories, a software ARC4
// model feeding a scoreboard of expected PT writes, plus latency and S-box checks.
module tb_prga;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;
  logic       pt_ok;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } pt_wr_t;

  logic [7:0] s_mem  [256];
  logic [7:0] ct_mem [256];
  logic [7:0] s_exp  [256];
  pt_wr_t     exp_q  [$];
  logic       exp_ok;
  int         s_writes;
  int         n_checks = 0;
  int         n_pass   = 0;

  prga dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren),
    .pt_ok     (pt_ok)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories with one-cycle latency.
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard side: every PT write must match the next queued expectation.
  always @(negedge clk) begin
    if (s_wren) s_writes++;
    if (s_wren && pt_wren) check("wr_excl", 32'd1, 32'd0);
    if (pt_wren) begin
      if (exp_q.size() == 0) begin
        check("pt_unexp", {24'd0, pt_addr}, 32'hFFFF);
      end else begin
        pt_wr_t e;
        e = exp_q.pop_front();
        check($sformatf("pt_addr[%0d]", e.addr), {24'd0, pt_addr}, {24'd0, e.addr});
        check($sformatf("pt_data[%0d]", e.addr), {24'd0, pt_wrdata}, {24'd0, e.data});
      end
    end
  end

  task automatic load_identity();
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
  endtask

  task automatic load_random_perm();
    logic [7:0] t;
    int r;
    load_identity();
    for (int x = 255; x > 0; x--) begin
      r        = $urandom_range(x, 0);
      t        = s_mem[x];
      s_mem[x] = s_mem[r];
      s_mem[r] = t;
    end
  endtask

  // Reference ARC4 PRGA on a private copy of S.
  task automatic build_expect(input int len);
    logic [7:0] ms [256];
    logic [7:0] mi, mj, t, pad;
    for (int x = 0; x < 256; x++) ms[x] = s_mem[x];
    mi = 8'd0;
    mj = 8'd0;
    exp_ok = 1'b1;
    exp_q.push_back('{addr: 8'd0, data: ct_mem[0]});
    for (int n = 1; n <= len; n++) begin
      mi     = mi + 8'd1;
      mj     = mj + ms[mi];
      t      = ms[mi];
      ms[mi] = ms[mj];
      ms[mj] = t;
      pad    = ms[8'(ms[mi] + ms[mj])];
      exp_q.push_back('{addr: 8'(n), data: pad ^ ct_mem[n]});
`ifdef PRGA_PRINTABLE_CHECK_EN
      if (((pad ^ ct_mem[n]) < 8'h20) || ((pad ^ ct_mem[n]) > 8'h7E)) exp_ok = 1'b0;
`endif
    end
    for (int x = 0; x < 256; x++) s_exp[x] = ms[x];
  endtask

  task automatic run_case(input string name, input int len, input bit hold);
    int lat;
    int mism;
    bit done;
    build_expect(len);
    s_writes = 0;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) en = 1'b0;
    check({name, "_rdy_drop"}, {31'd0, rdy}, 32'd0);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 3000) begin
      @(posedge clk);
      lat++;
      #1;
      if (rdy) done = 1'b1;
    end
    en = 1'b0;
    check({name, "_latency"}, lat, 32'(2 + 6 * len));
    check({name, "_q_empty"}, exp_q.size(), 32'd0);
    check({name, "_s_writes"}, s_writes, 32'(2 * len));
    mism = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== s_exp[x]) mism++;
    check({name, "_s_final"}, mism, 32'd0);
    check({name, "_pt_ok"}, {31'd0, pt_ok}, {31'd0, exp_ok});
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    load_identity();
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", {31'd0, rdy}, 32'd1);
    check("rst_pt_ok", {31'd0, pt_ok}, 32'd1);
    check("rst_wren", {30'd0, s_wren, pt_wren}, 32'd0);
    check("rst_addr", {8'd0, s_addr, ct_addr, pt_addr}, 32'd0);
    check("rst_wrdata", {16'd0, s_wrdata, pt_wrdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single byte, identity S: S stays identity, pt[1] = 0x41 ^ 2.
    ct_mem[0] = 8'd1; ct_mem[1] = 8'h41;
    run_case("l1", 1, 1'b0);

    // Two bytes: second byte swaps S[2]/S[3].
    load_identity();
    ct_mem[0] = 8'd2; ct_mem[1] = 8'h41; ct_mem[2] = 8'h00;
    run_case("l2", 2, 1'b0);
    check("l2_s2", {24'd0, s_mem[2]}, 32'd3);
    check("l2_s3", {24'd0, s_mem[3]}, 32'd2);

    // Zero length: only the length byte is copied.
    load_identity();
    ct_mem[0] = 8'd0;
    run_case("l0", 0, 1'b0);

    // Full-length message over a random permutation.
    load_random_perm();
    for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom_range(255, 0));
    ct_mem[0] = 8'd255;
    run_case("l255", 255, 1'b0);

    // Reset while in WR_I of byte 1 aborts the run.
    load_identity();
    ct_mem[0] = 8'd2; ct_mem[1] = 8'h41; ct_mem[2] = 8'h00;
    exp_q.push_back('{addr: 8'd0, data: 8'd2});
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_in_wr_i", {31'd0, s_wren}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_rdy", {31'd0, rdy}, 32'd1);
    check("abort_wren", {30'd0, s_wren, pt_wren}, 32'd0);
    check("abort_q_empty", exp_q.size(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    load_identity();
    run_case("after_abort", 2, 1'b0);

    // en held high through the whole run: exactly one run.
    load_identity();
    ct_mem[0] = 8'd1; ct_mem[1] = 8'h41;
    run_case("hold_en", 1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_no_restart", {31'd0, rdy}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
